// File: rtl/dts_ruler_reader.sv
// rtl/dts_ruler_reader.sv - snapshots a DTS ruler bus and streams its marks out one at a time
module dts_ruler_reader #(
  parameter int n = 3,
  parameter int M = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [n*(M+1)-1:0]       natRuler,
  output logic                     busy,
  output logic                     markValid,
  input  logic                     markReady,
  output logic [$clog2(M+1)-1:0]   mark,
  output logic [$clog2(n+1)-1:0]   blockIdx,
  output logic                     lastInBlock,
  output logic                     lastInSet,
  output logic                     done
);

  localparam int BW = $clog2(M+1);
  localparam int KW = $clog2(n+1);
  localparam int NB = n*(M+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [NB-1:0] snap_q, snap_d;
  logic [KW-1:0] blk_q, blk_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [BW-1:0] mark_q, mark_d;
  logic [KW-1:0] idx_q, idx_d;
  logic          lib_q, lib_d;
  logic          lis_q, lis_d;

  logic          cur_set, above_set, tail_set, last_pos;
  logic [KW-1:0] nxt_blk;
  logic [BW-1:0] nxt_bit;

  // Classify every snapshot bit relative to the current scan position.
  always_comb begin
    cur_set   = 1'b0;
    above_set = 1'b0;
    tail_set  = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((i / (M+1)) == int'(blk_q) && (i % (M+1)) == int'(bit_q)) cur_set = cur_set | snap_q[i];
      if ((i / (M+1)) == int'(blk_q) && (i % (M+1)) >  int'(bit_q)) above_set = above_set | snap_q[i];
      if ((i / (M+1)) >  int'(blk_q)) tail_set = tail_set | snap_q[i];
    end
  end

  always_comb begin
    last_pos = (blk_q == KW'(n-1)) && (bit_q == BW'(M));
    if (bit_q == BW'(M)) begin
      nxt_bit = '0;
      nxt_blk = blk_q + KW'(1);
    end else begin
      nxt_bit = bit_q + BW'(1);
      nxt_blk = blk_q;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    blk_d   = blk_q;
    bit_d   = bit_q;
    mark_d  = mark_q;
    idx_d   = idx_q;
    lib_d   = lib_q;
    lis_d   = lis_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = natRuler;
          blk_d   = '0;
          bit_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cur_set) begin
          mark_d  = bit_q;
          idx_d   = blk_q;
          lib_d   = !above_set;
          lis_d   = !above_set && !tail_set;
          state_d = S_EMIT;
        end else if (last_pos) begin
          state_d = S_DONE;
        end else begin
          blk_d = nxt_blk;
          bit_d = nxt_bit;
        end
      end
      S_EMIT: begin
        if (markReady) begin
          if (last_pos) begin
            state_d = S_DONE;
          end else begin
            blk_d   = nxt_blk;
            bit_d   = nxt_bit;
            state_d = S_SCAN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      blk_q   <= '0;
      bit_q   <= '0;
      mark_q  <= '0;
      idx_q   <= '0;
      lib_q   <= 1'b0;
      lis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      blk_q   <= blk_d;
      bit_q   <= bit_d;
      mark_q  <= mark_d;
      idx_q   <= idx_d;
      lib_q   <= lib_d;
      lis_q   <= lis_d;
    end
  end

  // Mark fields are qualified by markValid so they may hold stale values outside EMIT.
  assign busy        = (state_q != S_IDLE);
  assign markValid   = (state_q == S_EMIT);
  assign done        = (state_q == S_DONE);
  assign mark        = mark_q;
  assign blockIdx    = idx_q;
  assign lastInBlock = lib_q;
  assign lastInSet   = lis_q;

endmodule

// File: tb/tb_dts_ruler_reader.sv
// tb/tb_dts_ruler_reader.sv - randomized self-checking bench for dts_ruler_reader
module tb_dts_ruler_reader;

  localparam int N  = 3;
  localparam int MM = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [59:0] natRuler;
  logic        busy, markValid, done, lastInBlock, lastInSet;
  logic        markReady = 1'b0;
  logic [4:0]  mark;
  logic [1:0]  blockIdx;

  dts_ruler_reader #(.n(N), .M(MM)) dut (
    .clk(clk), .reset(reset), .start(start), .natRuler(natRuler),
    .busy(busy), .markValid(markValid), .markReady(markReady),
    .mark(mark), .blockIdx(blockIdx), .lastInBlock(lastInBlock),
    .lastInSet(lastInSet), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] blk;
    logic [4:0] mk;
    logic       lib;
    logic       lis;
  } ent_t;

  ent_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   stall_seen = 0;
  int   stall_left = 0;
  int   rdy_mode = 0;
  logic hold_valid = 1'b0;
  logic [1:0] hold_blk;
  logic [4:0] hold_mark;
  logic hold_lib, hold_lis;

  localparam logic [59:0] STREAM_A = {20'h00085, 20'h00211, 20'h0000B};
  localparam logic [59:0] STREAM_B = {20'h00000, 20'h00201, 20'h00001};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Expected mark list straight from the ruler bitmaps.
  function automatic void build(input logic [59:0] bus);
    ent_t e;
    logic [19:0] r;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      r = bus[k*20 +: 20];
      for (int j = 0; j < 20; j++) begin
        if (r[j]) begin
          e.blk = 2'(k);
          e.mk  = 5'(j);
          e.lib = ((r >> (j+1)) == 20'd0);
          e.lis = e.lib && ((bus >> ((k+1)*20)) == 60'd0);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: markReady = 1'b1;
      1: markReady = 1'($urandom_range(0, 1));
      2: begin
        if (markValid && blockIdx == 2'd1 && mark == 5'd4 && stall_left > 0) begin
          markReady = 1'b0;
          stall_left--;
        end else begin
          markReady = 1'b1;
        end
      end
      default: markReady = !(markValid && blockIdx == 2'd1 && mark == 5'd4);
    endcase
  end

  always @(negedge clk) begin
    if (!reset) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid)
        chk("hold_stable", {markValid, blockIdx, mark, lastInBlock, lastInSet},
            {1'b1, hold_blk, hold_mark, hold_lib, hold_lis});
      hold_valid = 1'b0;
      if (markValid) begin
        if (markReady) begin
          if (exp_q.size() == 0) begin
            chk("extra_mark", {blockIdx, mark}, 64'hFFFF);
          end else begin
            ent_t e;
            e = exp_q.pop_front();
            chk("mark_xfer", {blockIdx, mark, lastInBlock, lastInSet}, {e.blk, e.mk, e.lib, e.lis});
          end
        end else begin
          hold_valid = 1'b1;
          hold_blk   = blockIdx;
          hold_mark  = mark;
          hold_lib   = lastInBlock;
          hold_lis   = lastInSet;
          if (blockIdx == 2'd1 && mark == 5'd4) stall_seen++;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  task automatic run_readout(input logic [59:0] bus, input bit poke,
                             output int lat_v, output int lat_d);
    logic [63:0] junk;
    int c;
    build(bus);
    @(negedge clk);
    natRuler = bus;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    junk = {$urandom(), $urandom()};
    natRuler = junk[59:0];
    c = 0;
    lat_v = -1;
    lat_d = -1;
    while (lat_d < 0 && c < 3000) begin
      @(negedge clk);
      c++;
      start = poke && (c == 10);
      if (markValid && lat_v < 0) lat_v = c;
      if (done) lat_d = c;
    end
    if (lat_d < 0) chk("readout_timeout", 64'(c), 64'd0);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 2'b00);
  endtask

  initial begin
    int lv, ld, dc;
    reset = 1'b0;
    start = 1'b0;
    natRuler = '0;
    #1;
    chk("reset_state", {busy, markValid, done, mark, blockIdx, lastInBlock, lastInSet}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    build(STREAM_A);
    chk("model_a_size", 64'(exp_q.size()), 64'd9);
    chk("model_a_2", {exp_q[2].blk, exp_q[2].mk, exp_q[2].lib, exp_q[2].lis}, {2'd0, 5'd3, 1'b1, 1'b0});
    chk("model_a_4", {exp_q[4].blk, exp_q[4].mk, exp_q[4].lib, exp_q[4].lis}, {2'd1, 5'd4, 1'b0, 1'b0});
    chk("model_a_8", {exp_q[8].blk, exp_q[8].mk, exp_q[8].lib, exp_q[8].lis}, {2'd2, 5'd7, 1'b1, 1'b1});
    build(STREAM_B);
    chk("model_b_size", 64'(exp_q.size()), 64'd3);
    chk("model_b_2", {exp_q[2].blk, exp_q[2].mk, exp_q[2].lib, exp_q[2].lis}, {2'd1, 5'd9, 1'b1, 1'b1});

    rdy_mode = 0;
    dc = done_cnt;
    run_readout(STREAM_A, 1'b0, lv, ld);
    chk("stream_a_latency", 64'(lv), 64'd2);
    chk("stream_a_done_once", 64'(done_cnt - dc), 64'd1);

    rdy_mode = 2;
    stall_left = 3;
    stall_seen = 0;
    run_readout(STREAM_A, 1'b0, lv, ld);
    chk("backpressure_stalls", 64'(stall_seen), 64'd3);

    rdy_mode = 0;
    run_readout(STREAM_B, 1'b0, lv, ld);
    chk("empty_tail_queue", 64'(exp_q.size()), 64'd0);

    dc = done_cnt;
    run_readout(60'd0, 1'b1, lv, ld);
    chk("zero_no_valid", 64'(lv), -64'sd1);
    chk("zero_done_latency", 64'(ld), 64'd61);
    chk("zero_done_once", 64'(done_cnt - dc), 64'd1);

    rdy_mode = 3;
    build(STREAM_A);
    @(negedge clk);
    natRuler = STREAM_A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int w;
      w = 0;
      while (!(markValid && blockIdx == 2'd1 && mark == 5'd4) && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("reach_1_4", 64'(w < 300), 64'd1);
    end
    dc = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_emit", {busy, markValid, done, mark, blockIdx}, 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_abort", 64'(done_cnt - dc), 64'd0);
    rdy_mode = 0;
    run_readout(STREAM_A, 1'b0, lv, ld);
    chk("restart_latency", 64'(lv), 64'd2);
    chk("restart_done_once", 64'(done_cnt - dc), 64'd1);

    rdy_mode = 1;
    for (int it = 0; it < 8; it++) begin
      logic [59:0] bus;
      for (int k = 0; k < N; k++)
        bus[k*20 +: 20] = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom() & $urandom());
      dc = done_cnt;
      run_readout(bus, 1'b0, lv, ld);
      chk("rand_done_once", 64'(done_cnt - dc), 64'd1);
      chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
